// File: rtl/mcs8_io_responder.sv
// MCS-8 IO bus responder: input ports 0-7 with 1-deep holding buffers, output ports 8-31 with write strobes.
// Optional MCS8_IO_STATUS_EN turns input port 7 into a read-only buffer-status register.
module mcs8_io_responder #(
  parameter logic [7:0] OUT_RST = 8'h00,
  parameter logic [7:0] IN_RST  = 8'h00
) (
  input  logic         CLK_I,
  input  logic         nRST_I,
  input  logic [4:0]   IO_ADDR_I,
  input  logic [7:0]   IO_DAT_I,
  input  logic         IO_WR_I,
  input  logic         IO_RD_I,
  output logic [7:0]   IO_DAT_O,
  output logic [191:0] OUT_DAT_O,
  output logic [23:0]  OUT_STB_O,
  input  logic [63:0]  PIN_DAT_I,
  input  logic [7:0]   PIN_VLD_I,
  output logic [7:0]   PIN_RDY_O
);

  localparam int NOUT = 24;
  localparam int NIN  = 8;

`ifdef MCS8_IO_STATUS_EN
  localparam bit STATUS_EN = 1'b1;
`else
  localparam bit STATUS_EN = 1'b0;
`endif

  logic [NOUT-1:0][7:0] out_q, out_d;
  logic [NOUT-1:0]      stb_q, stb_d;
  logic [NIN-1:0][7:0]  hold_q, hold_d;
  logic [NIN-1:0]       full_q, full_d;
  logic [7:0]           io_dat_q, io_dat_d;

  logic           is_out;
  logic           wr_en;
  logic           rd_en;
  logic [4:0]     out_idx;
  logic [2:0]     in_idx;
  logic [NIN-1:0] rdy;
  logic [NIN-1:0] cap;
  logic [NIN-1:0] rd_clr;

  assign is_out  = IO_ADDR_I[4] | IO_ADDR_I[3];
  assign out_idx = IO_ADDR_I - 5'd8;
  assign in_idx  = IO_ADDR_I[2:0];
  assign wr_en   = IO_WR_I & is_out;
  // A write always wins over a same-cycle read; the read is dropped entirely.
  assign rd_en   = IO_RD_I & ~IO_WR_I;

  // Peripheral handshake: a byte transfers on a rising edge where PIN_VLD_I[n] and
  // PIN_RDY_O[n] are both high; the peripheral holds data/valid until that edge.
  assign rdy = STATUS_EN ? {1'b0, ~full_q[6:0]} : ~full_q;
  assign cap = PIN_VLD_I & rdy;

  always_comb begin
    out_d    = out_q;
    stb_d    = '0;
    hold_d   = hold_q;
    io_dat_d = io_dat_q;
    rd_clr   = '0;

    if (wr_en) begin
      out_d[out_idx] = IO_DAT_I;
      stb_d[out_idx] = 1'b1;
    end

    if (rd_en) begin
      if (is_out) begin
        io_dat_d = out_q[out_idx];
      end else if (STATUS_EN && (in_idx == 3'd7)) begin
        io_dat_d = {1'b0, full_q[6:0]};
      end else begin
        io_dat_d       = hold_q[in_idx];
        rd_clr[in_idx] = 1'b1;
      end
    end

    // Capture only happens into an empty buffer, so a same-edge read sees the old byte.
    for (int n = 0; n < NIN; n++) begin
      if (cap[n]) hold_d[n] = PIN_DAT_I[n*8 +: 8];
    end
    full_d = (full_q & ~rd_clr) | cap;
  end

  always_ff @(posedge CLK_I or negedge nRST_I) begin
    if (!nRST_I) begin
      out_q    <= {NOUT{OUT_RST}};
      stb_q    <= '0;
      hold_q   <= {NIN{IN_RST}};
      full_q   <= '0;
      io_dat_q <= 8'h00;
    end else begin
      out_q    <= out_d;
      stb_q    <= stb_d;
      hold_q   <= hold_d;
      full_q   <= full_d;
      io_dat_q <= io_dat_d;
    end
  end

  assign IO_DAT_O  = io_dat_q;
  assign OUT_DAT_O = out_q;
  assign OUT_STB_O = stb_q;
  assign PIN_RDY_O = rdy;

endmodule

// File: tb/tb_mcs8_io_responder.sv
// Self-checking bench for mcs8_io_responder: directed scenarios plus a randomized run
// checked against a transaction-level model of the port map.
module tb_mcs8_io_responder;

  localparam logic [7:0] OUT_RST_T = 8'hC3;
  localparam logic [7:0] IN_RST_T  = 8'h5E;
`ifdef MCS8_IO_STATUS_EN
  localparam bit         STATUS    = 1'b1;
  localparam logic [7:0] RDY_RST   = 8'h7F;
`else
  localparam bit         STATUS    = 1'b0;
  localparam logic [7:0] RDY_RST   = 8'hFF;
`endif

  logic         CLK_I;
  logic         nRST_I;
  logic [4:0]   IO_ADDR_I;
  logic [7:0]   IO_DAT_I;
  logic         IO_WR_I;
  logic         IO_RD_I;
  logic [7:0]   IO_DAT_O;
  logic [191:0] OUT_DAT_O;
  logic [23:0]  OUT_STB_O;
  logic [63:0]  PIN_DAT_I;
  logic [7:0]   PIN_VLD_I;
  logic [7:0]   PIN_RDY_O;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state
  logic [7:0]  out_m [24];
  logic [7:0]  hold_m [8];
  logic [7:0]  full_m;
  logic [7:0]  io_m;
  logic [23:0] stb_m;

  mcs8_io_responder #(.OUT_RST(OUT_RST_T), .IN_RST(IN_RST_T)) dut (
    .CLK_I     (CLK_I),
    .nRST_I    (nRST_I),
    .IO_ADDR_I (IO_ADDR_I),
    .IO_DAT_I  (IO_DAT_I),
    .IO_WR_I   (IO_WR_I),
    .IO_RD_I   (IO_RD_I),
    .IO_DAT_O  (IO_DAT_O),
    .OUT_DAT_O (OUT_DAT_O),
    .OUT_STB_O (OUT_STB_O),
    .PIN_DAT_I (PIN_DAT_I),
    .PIN_VLD_I (PIN_VLD_I),
    .PIN_RDY_O (PIN_RDY_O)
  );

  // Clock and watchdog
  initial begin
    CLK_I = 1'b0;
    forever #5 CLK_I = ~CLK_I;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Model
  task automatic model_reset();
    for (int i = 0; i < 24; i++) out_m[i] = OUT_RST_T;
    for (int i = 0; i < 8; i++) hold_m[i] = IN_RST_T;
    full_m = 8'h00;
    io_m   = 8'h00;
    stb_m  = '0;
  endtask

  function automatic logic [7:0] model_rdy();
    logic [7:0] r;
    r = ~full_m;
    if (STATUS) r[7] = 1'b0;
    return r;
  endfunction

  function automatic logic [191:0] model_out_flat();
    logic [191:0] f;
    for (int i = 0; i < 24; i++) f[i*8 +: 8] = out_m[i];
    return f;
  endfunction

  task automatic model_edge();
    int a;
    logic [7:0] rdy_before;
    a = int'(IO_ADDR_I);
    rdy_before = model_rdy();
    stb_m = '0;
    if (IO_RD_I && !IO_WR_I) begin
      if (a >= 8) io_m = out_m[a-8];
      else if (STATUS && a == 7) io_m = {1'b0, full_m[6:0]};
      else begin
        io_m = hold_m[a];
        full_m[a] = 1'b0;
      end
    end
    if (IO_WR_I && a >= 8) begin
      out_m[a-8] = IO_DAT_I;
      stb_m[a-8] = 1'b1;
    end
    for (int n = 0; n < 8; n++) begin
      if (PIN_VLD_I[n] && rdy_before[n]) begin
        hold_m[n] = PIN_DAT_I[n*8 +: 8];
        full_m[n] = 1'b1;
      end
    end
  endtask

  // Drivers
  task automatic tick();
    @(posedge CLK_I);
    model_edge();
    #1;
  endtask

  task automatic cpu_write(input logic [4:0] addr, input logic [7:0] dat);
    IO_ADDR_I = addr;
    IO_DAT_I  = dat;
    IO_WR_I   = 1'b1;
    tick();
    IO_WR_I   = 1'b0;
  endtask

  task automatic cpu_read(input logic [4:0] addr);
    IO_ADDR_I = addr;
    IO_RD_I   = 1'b1;
    tick();
    IO_RD_I   = 1'b0;
  endtask

  task automatic release_reset();
    @(posedge CLK_I);
    @(negedge CLK_I);
    nRST_I = 1'b1;
    model_reset();
  endtask

  // Scenarios
  task automatic test_reset();
    #2 nRST_I = 1'b0;
    #1;
    tests_run++;
    if (IO_DAT_O !== 8'h00) begin tests_failed++; $display("FAIL rst_io_dat: got %h expected %h", IO_DAT_O, 8'h00); end
    tests_run++;
    if (OUT_STB_O !== 24'h0) begin tests_failed++; $display("FAIL rst_stb: got %h expected %h", OUT_STB_O, 24'h0); end
    tests_run++;
    if (PIN_RDY_O !== RDY_RST) begin tests_failed++; $display("FAIL rst_rdy: got %h expected %h", PIN_RDY_O, RDY_RST); end
    tests_run++;
    if (OUT_DAT_O !== {24{OUT_RST_T}}) begin tests_failed++; $display("FAIL rst_out_dat: got %h expected %h", OUT_DAT_O, {24{OUT_RST_T}}); end
    release_reset();
  endtask

  task automatic test_write();
    cpu_write(5'd8, 8'hA5);
    tests_run++;
    if (OUT_STB_O !== 24'h000001) begin tests_failed++; $display("FAIL wr8_stb: got %h expected %h", OUT_STB_O, 24'h000001); end
    tests_run++;
    if (OUT_DAT_O[7:0] !== 8'hA5) begin tests_failed++; $display("FAIL wr8_dat: got %h expected %h", OUT_DAT_O[7:0], 8'hA5); end
    cpu_write(5'd31, 8'h3C);
    tests_run++;
    if (OUT_STB_O !== 24'h800000) begin tests_failed++; $display("FAIL wr31_stb: got %h expected %h", OUT_STB_O, 24'h800000); end
    tests_run++;
    if (OUT_DAT_O[191:184] !== 8'h3C) begin tests_failed++; $display("FAIL wr31_dat: got %h expected %h", OUT_DAT_O[191:184], 8'h3C); end
    tick();
    tests_run++;
    if (OUT_STB_O !== 24'h0) begin tests_failed++; $display("FAIL wr31_stb_end: got %h expected %h", OUT_STB_O, 24'h0); end
    cpu_write(5'd3, 8'hFF);
    tests_run++;
    if (OUT_STB_O !== 24'h0) begin tests_failed++; $display("FAIL wr3_stb: got %h expected %h", OUT_STB_O, 24'h0); end
    tests_run++;
    if (OUT_DAT_O !== {8'h3C, {22{OUT_RST_T}}, 8'hA5}) begin tests_failed++; $display("FAIL wr3_out: got %h expected %h", OUT_DAT_O, {8'h3C, {22{OUT_RST_T}}, 8'hA5}); end
    cpu_read(5'd3);
    tests_run++;
    if (IO_DAT_O !== IN_RST_T) begin tests_failed++; $display("FAIL wr3_hold: got %h expected %h", IO_DAT_O, IN_RST_T); end
    cpu_read(5'd31);
    tests_run++;
    if (IO_DAT_O !== 8'h3C) begin tests_failed++; $display("FAIL rd31: got %h expected %h", IO_DAT_O, 8'h3C); end
  endtask

  task automatic test_capture();
    PIN_DAT_I[23:16] = 8'h5A;
    PIN_VLD_I[2]     = 1'b1;
    tick();
    tests_run++;
    if (PIN_RDY_O !== (RDY_RST & ~8'h04)) begin tests_failed++; $display("FAIL cap_rdy_drop: got %h expected %h", PIN_RDY_O, RDY_RST & ~8'h04); end
    PIN_DAT_I[23:16] = 8'h77;
    tick();
    tick();
    cpu_read(5'd2);
    tests_run++;
    if (IO_DAT_O !== 8'h5A) begin tests_failed++; $display("FAIL cap_read: got %h expected %h", IO_DAT_O, 8'h5A); end
    tests_run++;
    if (PIN_RDY_O !== RDY_RST) begin tests_failed++; $display("FAIL cap_rdy_back: got %h expected %h", PIN_RDY_O, RDY_RST); end
    tick();
    PIN_VLD_I[2] = 1'b0;
    tests_run++;
    if (PIN_RDY_O !== (RDY_RST & ~8'h04)) begin tests_failed++; $display("FAIL cap2_rdy: got %h expected %h", PIN_RDY_O, RDY_RST & ~8'h04); end
    cpu_read(5'd2);
    tests_run++;
    if (IO_DAT_O !== 8'h77) begin tests_failed++; $display("FAIL cap2_read: got %h expected %h", IO_DAT_O, 8'h77); end
  endtask

  task automatic test_same_edge();
    cpu_read(5'd5);
    tests_run++;
    if (IO_DAT_O !== IN_RST_T) begin tests_failed++; $display("FAIL empty_read: got %h expected %h", IO_DAT_O, IN_RST_T); end
    PIN_DAT_I[39:32] = 8'h11;
    PIN_VLD_I[4]     = 1'b1;
    tick();
    PIN_VLD_I[4]     = 1'b0;
    cpu_read(5'd4);
    tests_run++;
    if (IO_DAT_O !== 8'h11) begin tests_failed++; $display("FAIL se_prep: got %h expected %h", IO_DAT_O, 8'h11); end
    PIN_DAT_I[39:32] = 8'h99;
    PIN_VLD_I[4]     = 1'b1;
    cpu_read(5'd4);
    PIN_VLD_I[4]     = 1'b0;
    tests_run++;
    if (IO_DAT_O !== 8'h11) begin tests_failed++; $display("FAIL se_read_old: got %h expected %h", IO_DAT_O, 8'h11); end
    tests_run++;
    if (PIN_RDY_O[4] !== 1'b0) begin tests_failed++; $display("FAIL se_full: got %b expected %b", PIN_RDY_O[4], 1'b0); end
    cpu_read(5'd4);
    tests_run++;
    if (IO_DAT_O !== 8'h99) begin tests_failed++; $display("FAIL se_read_new: got %h expected %h", IO_DAT_O, 8'h99); end
    tests_run++;
    if (PIN_RDY_O[4] !== 1'b1) begin tests_failed++; $display("FAIL se_rdy: got %b expected %b", PIN_RDY_O[4], 1'b1); end
    cpu_read(5'd4);
    tests_run++;
    if (IO_DAT_O !== 8'h99) begin tests_failed++; $display("FAIL b2b_read: got %h expected %h", IO_DAT_O, 8'h99); end
    tests_run++;
    if (PIN_RDY_O !== RDY_RST) begin tests_failed++; $display("FAIL b2b_rdy: got %h expected %h", PIN_RDY_O, RDY_RST); end
  endtask

  task automatic test_back_to_back();
    IO_ADDR_I = 5'd9;
    IO_DAT_I  = 8'hF0;
    IO_WR_I   = 1'b1;
    IO_RD_I   = 1'b1;
    tick();
    IO_WR_I   = 1'b0;
    IO_RD_I   = 1'b0;
    tests_run++;
    if (OUT_STB_O !== 24'h000002) begin tests_failed++; $display("FAIL wrrd_stb: got %h expected %h", OUT_STB_O, 24'h000002); end
    tests_run++;
    if (OUT_DAT_O[15:8] !== 8'hF0) begin tests_failed++; $display("FAIL wrrd_dat: got %h expected %h", OUT_DAT_O[15:8], 8'hF0); end
    tests_run++;
    if (IO_DAT_O !== 8'h99) begin tests_failed++; $display("FAIL wrrd_io_keep: got %h expected %h", IO_DAT_O, 8'h99); end
    cpu_read(5'd9);
    tests_run++;
    if (IO_DAT_O !== 8'hF0) begin tests_failed++; $display("FAIL rd9: got %h expected %h", IO_DAT_O, 8'hF0); end
    cpu_write(5'd12, 8'hAA);
    tests_run++;
    if (OUT_STB_O !== 24'h000010) begin tests_failed++; $display("FAIL ww1_stb: got %h expected %h", OUT_STB_O, 24'h000010); end
    cpu_write(5'd12, 8'hBB);
    tests_run++;
    if (OUT_STB_O !== 24'h000010) begin tests_failed++; $display("FAIL ww2_stb: got %h expected %h", OUT_STB_O, 24'h000010); end
    tests_run++;
    if (OUT_DAT_O[39:32] !== 8'hBB) begin tests_failed++; $display("FAIL ww_last: got %h expected %h", OUT_DAT_O[39:32], 8'hBB); end
    tick();
    tests_run++;
    if (OUT_STB_O !== 24'h0) begin tests_failed++; $display("FAIL ww_stb_end: got %h expected %h", OUT_STB_O, 24'h0); end
  endtask

  task automatic test_port7();
    PIN_DAT_I[7:0]   = 8'h21;
    PIN_DAT_I[55:48] = 8'h66;
    PIN_DAT_I[63:56] = 8'h77;
`ifdef MCS8_IO_STATUS_EN
    PIN_VLD_I = 8'hC1;
    tick();
    PIN_VLD_I = 8'h00;
    tests_run++;
    if (PIN_RDY_O !== 8'h3E) begin tests_failed++; $display("FAIL st_rdy: got %h expected %h", PIN_RDY_O, 8'h3E); end
    cpu_read(5'd7);
    tests_run++;
    if (IO_DAT_O !== 8'h41) begin tests_failed++; $display("FAIL st_read: got %h expected %h", IO_DAT_O, 8'h41); end
    cpu_read(5'd7);
    tests_run++;
    if (IO_DAT_O !== 8'h41) begin tests_failed++; $display("FAIL st_read2: got %h expected %h", IO_DAT_O, 8'h41); end
    tests_run++;
    if (PIN_RDY_O !== 8'h3E) begin tests_failed++; $display("FAIL st_keep: got %h expected %h", PIN_RDY_O, 8'h3E); end
    cpu_read(5'd0);
    cpu_read(5'd6);
    tests_run++;
    if (IO_DAT_O !== 8'h66) begin tests_failed++; $display("FAIL st_rd6: got %h expected %h", IO_DAT_O, 8'h66); end
    tests_run++;
    if (PIN_RDY_O !== 8'h7F) begin tests_failed++; $display("FAIL st_rdy_end: got %h expected %h", PIN_RDY_O, 8'h7F); end
`else
    PIN_VLD_I = 8'h81;
    tick();
    PIN_VLD_I = 8'h00;
    tests_run++;
    if (PIN_RDY_O !== 8'h7E) begin tests_failed++; $display("FAIL p7_rdy: got %h expected %h", PIN_RDY_O, 8'h7E); end
    cpu_read(5'd7);
    tests_run++;
    if (IO_DAT_O !== 8'h77) begin tests_failed++; $display("FAIL p7_read: got %h expected %h", IO_DAT_O, 8'h77); end
    tests_run++;
    if (PIN_RDY_O !== 8'hFE) begin tests_failed++; $display("FAIL p7_rdy_back: got %h expected %h", PIN_RDY_O, 8'hFE); end
    cpu_read(5'd0);
    tests_run++;
    if (IO_DAT_O !== 8'h21) begin tests_failed++; $display("FAIL p0_read: got %h expected %h", IO_DAT_O, 8'h21); end
`endif
  endtask

  task automatic test_reset_mid();
    IO_ADDR_I        = 5'd20;
    IO_DAT_I         = 8'h66;
    IO_WR_I          = 1'b1;
    PIN_DAT_I[15:8]  = 8'h4D;
    PIN_VLD_I[1]     = 1'b1;
    tick();
    IO_WR_I          = 1'b0;
    PIN_VLD_I[1]     = 1'b0;
    tests_run++;
    if (OUT_STB_O !== 24'h001000) begin tests_failed++; $display("FAIL mid_stb_pre: got %h expected %h", OUT_STB_O, 24'h001000); end
    #2 nRST_I = 1'b0;
    #1;
    tests_run++;
    if (OUT_STB_O !== 24'h0) begin tests_failed++; $display("FAIL mid_stb: got %h expected %h", OUT_STB_O, 24'h0); end
    tests_run++;
    if (PIN_RDY_O !== RDY_RST) begin tests_failed++; $display("FAIL mid_rdy: got %h expected %h", PIN_RDY_O, RDY_RST); end
    tests_run++;
    if (OUT_DAT_O !== {24{OUT_RST_T}}) begin tests_failed++; $display("FAIL mid_out: got %h expected %h", OUT_DAT_O, {24{OUT_RST_T}}); end
    tests_run++;
    if (IO_DAT_O !== 8'h00) begin tests_failed++; $display("FAIL mid_io: got %h expected %h", IO_DAT_O, 8'h00); end
    release_reset();
    cpu_read(5'd1);
    tests_run++;
    if (IO_DAT_O !== IN_RST_T) begin tests_failed++; $display("FAIL mid_hold: got %h expected %h", IO_DAT_O, IN_RST_T); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      IO_ADDR_I = 5'($urandom_range(0, 31));
      IO_DAT_I  = 8'($urandom);
      IO_WR_I   = ($urandom_range(0, 3) == 0);
      IO_RD_I   = ($urandom_range(0, 2) == 0);
      PIN_VLD_I = 8'($urandom);
      PIN_DAT_I = {$urandom, $urandom};
      tick();
      tests_run++;
      if (IO_DAT_O !== io_m) begin tests_failed++; $display("FAIL rnd_io_dat[%0d]: got %h expected %h", i, IO_DAT_O, io_m); end
      tests_run++;
      if (OUT_STB_O !== stb_m) begin tests_failed++; $display("FAIL rnd_stb[%0d]: got %h expected %h", i, OUT_STB_O, stb_m); end
      tests_run++;
      if (PIN_RDY_O !== model_rdy()) begin tests_failed++; $display("FAIL rnd_rdy[%0d]: got %h expected %h", i, PIN_RDY_O, model_rdy()); end
      tests_run++;
      if (OUT_DAT_O !== model_out_flat()) begin tests_failed++; $display("FAIL rnd_out[%0d]: got %h expected %h", i, OUT_DAT_O, model_out_flat()); end
    end
    IO_WR_I   = 1'b0;
    IO_RD_I   = 1'b0;
    PIN_VLD_I = 8'h00;
  endtask

  initial begin
    nRST_I    = 1'b1;
    IO_ADDR_I = 5'd0;
    IO_DAT_I  = 8'h00;
    IO_WR_I   = 1'b0;
    IO_RD_I   = 1'b0;
    PIN_DAT_I = '0;
    PIN_VLD_I = 8'h00;
    model_reset();

    test_reset();
    test_write();
    test_capture();
    test_same_edge();
    test_back_to_back();
    test_port7();
    test_reset_mid();
    test_random();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
